// File: rtl/serial_adder_pkg.sv
// Shared arithmetic types for the serial adder.
// FSM state enum plus a counter-width helper.
package arith_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Bits needed to count 0..w inclusive.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result bundle of the serial adder.
// slave: DUT side; master: requester side.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder_full_adder_cell.sv
// One-bit full adder from two half-add stages.
// Ports: x, y, ci -> s, co (combinational).
module full_adder_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s1;
  logic c1;
  logic c2;

  assign s1 = x ^ y;
  assign c1 = x & y;
  assign s  = s1 ^ ci;
  assign c2 = s1 & ci;
  assign co = c1 | c2;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one FA cell.
// Ports: clk, rst_n, bus (slave: start,a,b,cin -> busy,done,sum,cout).
module serial_adder
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_adder_if.slave   bus
);
  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] res_sh;

  full_adder_cell u_fa (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // New bit enters at the MSB; after WIDTH steps bit 0 sits at the LSB.
  assign res_sh = (res_q >> 1)
                | (WIDTH'(fa_s) << (WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (bus.start) begin
          state_d = RUN;
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          res_d   = '0;
        end
      end
      (state_q == RUN): begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_co;
        res_d   = res_sh;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = IDLE;
          sum_d   = res_sh;
          cout_d  = fa_co;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH 8 and 1).
// Reference: {cout,sum} = a + b + cin computed arithmetically.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) b8 ();
  serial_adder_if #(.WIDTH(1)) b1 ();

  serial_adder #(.WIDTH(8)) u8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b8)
  );

  serial_adder #(.WIDTH(1)) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait8(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!b8.done && n < 40);
  endtask

  task automatic wait1(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!b1.done && n < 10);
  endtask

  task automatic add8(input string tag, input logic [7:0] a,
                      input logic [7:0] b, input logic c);
    logic [8:0] e;
    int n;
    e = 9'(a) + 9'(b) + 9'(c);
    b8.a = a;
    b8.b = b;
    b8.cin = c;
    b8.start = 1'b1;
    tick();
    b8.start = 1'b0;
    chk({tag, ".busy"}, 32'(b8.busy), 32'd1);
    wait8(n);
    chk({tag, ".lat"}, 32'(n), 32'd8);
    chk({tag, ".sum"}, 32'(b8.sum), 32'(e[7:0]));
    chk({tag, ".cout"}, 32'(b8.cout), 32'(e[8]));
    tick();
    chk({tag, ".pulse"}, 32'(b8.done), 32'd0);
    chk({tag, ".idle"}, 32'(b8.busy), 32'd0);
  endtask

  task automatic add1(input string tag, input logic a,
                      input logic b, input logic c);
    logic [1:0] e;
    int n;
    e = 2'(a) + 2'(b) + 2'(c);
    b1.a = a;
    b1.b = b;
    b1.cin = c;
    b1.start = 1'b1;
    tick();
    b1.start = 1'b0;
    wait1(n);
    chk({tag, ".lat"}, 32'(n), 32'd1);
    chk({tag, ".sum"}, 32'({b1.cout, b1.sum}), 32'(e));
    tick();
    chk({tag, ".pulse"}, 32'(b1.done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int ndone;
    int first;
    int d1, d2;
    logic [8:0] e1, e2, r1, r2;
    logic [7:0] ra, rb;
    logic rc;

    b8.start = 1'b0; b8.a = '0; b8.b = '0; b8.cin = 1'b0;
    b1.start = 1'b0; b1.a = '0; b1.b = '0; b1.cin = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    chk("rst.busy", 32'(b8.busy), 32'd0);
    chk("rst.done", 32'(b8.done), 32'd0);
    chk("rst.sum", 32'(b8.sum), 32'd0);
    chk("rst.cout", 32'(b8.cout), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    add8("ff01", 8'hFF, 8'h01, 1'b0);
    add8("0503", 8'h05, 8'h03, 1'b1);
    b8.a = 8'h77;
    b8.b = 8'h11;
    repeat (5) begin
      tick();
      chk("hold.sum", 32'(b8.sum), 32'h09);
      chk("hold.busy", 32'(b8.busy), 32'd0);
    end

    // Second start during RUN must be ignored.
    b8.a = 8'h12; b8.b = 8'h34; b8.cin = 1'b0;
    b8.start = 1'b1;
    tick();
    b8.start = 1'b0;
    ndone = 0;
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 4) begin
        b8.a = 8'hAA;
        b8.b = 8'h55;
        b8.start = 1'b1;
      end
      tick();
      if (i == 4) b8.start = 1'b0;
      if (b8.done) begin
        ndone++;
        if (first == 0) first = i;
      end
    end
    chk("ign.lat", 32'(first), 32'd8);
    chk("ign.ndone", 32'(ndone), 32'd1);
    chk("ign.sum", 32'(b8.sum), 32'h46);
    chk("ign.busy", 32'(b8.busy), 32'd0);

    // Asynchronous reset in the middle of RUN.
    b8.a = 8'hF0; b8.b = 8'hF0; b8.cin = 1'b1;
    b8.start = 1'b1;
    tick();
    b8.start = 1'b0;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst.busy", 32'(b8.busy), 32'd0);
    chk("arst.done", 32'(b8.done), 32'd0);
    chk("arst.sum", 32'(b8.sum), 32'd0);
    chk("arst.cout", 32'(b8.cout), 32'd0);
    tick();
    rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      tick();
      if (b8.done) ndone++;
    end
    chk("arst.nodone", 32'(ndone), 32'd0);
    add8("postrst", 8'hC8, 8'h64, 1'b1);

    // start held high: accepts at edge 0 and, from IDLE, at edge 9.
    e1 = 9'h03C + 9'h0C3 + 9'd1;
    e2 = 9'h081 + 9'h090;
    b8.a = 8'h3C; b8.b = 8'hC3; b8.cin = 1'b1;
    b8.start = 1'b1;
    tick();
    b8.a = 8'h81; b8.b = 8'h90; b8.cin = 1'b0;
    d1 = 0; d2 = 0;
    r1 = '0; r2 = '0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (i == 9) begin
        b8.start = 1'b0;
        chk("held.busy9", 32'(b8.busy), 32'd1);
        chk("held.keep", 32'({b8.cout, b8.sum}), 32'(e1));
      end
      if (b8.done) begin
        if (d1 == 0) begin
          d1 = i;
          r1 = {b8.cout, b8.sum};
        end else if (d2 == 0) begin
          d2 = i;
          r2 = {b8.cout, b8.sum};
        end
      end
    end
    chk("held.d1", 32'(d1), 32'd8);
    chk("held.d2", 32'(d2), 32'd17);
    chk("held.r1", 32'(r1), 32'(e1));
    chk("held.r2", 32'(r2), 32'(e2));

    for (int k = 0; k < 20; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      add8("rand", ra, rb, rc);
    end

    for (int v = 0; v < 8; v++) begin
      add1("w1", v[2], v[1], v[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
